// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline definitions: memory op one-hot bit positions and
// the memory-stage FSM encoding.
package mips_pkg;

  localparam int LD_LB  = 0;
  localparam int LD_LBU = 1;
  localparam int LD_LH  = 2;
  localparam int LD_LHU = 3;
  localparam int LD_LW  = 4;

  localparam int ST_SB = 0;
  localparam int ST_SH = 1;
  localparam int ST_SW = 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic for the memory stage: store byte enables and lane
// replication, load lane extraction with sign/zero extension, alignment check.
module mem_align
  import mips_pkg::*;
(
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic [8:0]  load_op_i,
  input  logic [5:0]  store_op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic        misaligned_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic       ld_b, ld_h, ld_w, ld_sext;
  logic       st_b, st_h, st_w;
  logic       ld_mis, st_mis;
  logic [7:0] byte_lane;
  logic [15:0] half_lane;

  // Lower op bits win; reserved encodings and an empty op decode as a word.
  assign ld_b = load_op_i[LD_LB] | load_op_i[LD_LBU];
  assign ld_h = ~ld_b & (load_op_i[LD_LH] | load_op_i[LD_LHU]);
  assign ld_w = ~ld_b & ~ld_h & ((|load_op_i[8:LD_LW]) | ~(|load_op_i));
  assign ld_sext = ld_b ? load_op_i[LD_LB] : load_op_i[LD_LH];

  assign st_b = store_op_i[ST_SB];
  assign st_h = ~st_b & store_op_i[ST_SH];
  assign st_w = ~st_b & ~st_h & ((|store_op_i[5:ST_SW]) | ~(|store_op_i));

  assign ld_mis = (ld_h & addr_lo_i[0]) | (ld_w & (|addr_lo_i));
  assign st_mis = (st_h & addr_lo_i[0]) | (st_w & (|addr_lo_i));
  assign misaligned_o = (memread_i & ld_mis) | (memwrite_i & st_mis);

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = 32'h0;
    if (memwrite_i) begin
      if (st_b) begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end else if (st_h) begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{store_data_i[15:0]}};
      end else begin
        wdata_o = store_data_i;
      end
    end
  end

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_lane = rdata_i[7:0];
      2'd1:    byte_lane = rdata_i[15:8];
      2'd2:    byte_lane = rdata_i[23:16];
      default: byte_lane = rdata_i[31:24];
    endcase
    half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    if (ld_b)
      load_data_o = {{24{ld_sext & byte_lane[7]}}, byte_lane};
    else if (ld_h)
      load_data_o = {{16{ld_sext & half_lane[15]}}, half_lane};
    else
      load_data_o = rdata_i;
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS32 memory-access stage: data-memory handshake FSM with timeout,
// pipeline stall generation and the MEM/WB pipeline register.
module mem_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        M_regwrite,
  input  logic        M_memtoreg,
  input  logic        M_memread,
  input  logic        M_memwrite,
  input  logic [31:0] M_memaddr,
  input  logic [8:0]  M_load_op,
  input  logic [5:0]  M_store_op,
  input  logic [31:0] M_store_data,
  input  logic [31:0] M_alu_out,
  input  logic [4:0]  M_rt_rd,
  output logic        M_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        W_regwrite,
  output logic        W_memtoreg,
  output logic [4:0]  W_rt_rd,
  output logic [31:0] W_alu_out,
  output logic [31:0] W_mem_data,
  output logic        W_addr_err,
  output logic        W_bus_err
);

  mem_state_e      state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            misaligned, access, complete, bus_err, req_c;
  logic [31:0]     load_data;

  mem_align u_align (
    .memread_i    (M_memread),
    .memwrite_i   (M_memwrite),
    .load_op_i    (M_load_op),
    .store_op_i   (M_store_op),
    .addr_lo_i    (M_memaddr[1:0]),
    .store_data_i (M_store_data),
    .rdata_i      (dmem_rdata),
    .misaligned_o (misaligned),
    .be_o         (dmem_be),
    .wdata_o      (dmem_wdata),
    .load_data_o  (load_data)
  );

  assign access    = (M_memread | M_memwrite) & ~misaligned;
  assign dmem_we   = M_memwrite;
  assign dmem_addr = {M_memaddr[31:2], 2'b00};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_c    = 1'b0;
    complete = 1'b0;
    bus_err  = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_c = access;
        if (access) begin
          if (dmem_ack) begin
            complete = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        req_c = 1'b1;
        cnt_d = cnt_q + TO_W'(1);
        if (dmem_ack) begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          // Abandon the access: request drops in the same cycle it is retired.
          complete = 1'b1;
          bus_err  = 1'b1;
          req_c    = 1'b0;
          state_d  = S_IDLE;
        end
      end
    endcase
  end

  assign M_stall  = access & ~complete;
  assign dmem_req = req_c & rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      W_regwrite <= 1'b0;
      W_memtoreg <= 1'b0;
      W_rt_rd    <= 5'd0;
      W_alu_out  <= 32'h0;
      W_mem_data <= 32'h0;
      W_addr_err <= 1'b0;
      W_bus_err  <= 1'b0;
    end else if (M_stall) begin
      W_regwrite <= 1'b0;
      W_addr_err <= 1'b0;
      W_bus_err  <= 1'b0;
    end else begin
      W_regwrite <= M_regwrite & ~misaligned & ~bus_err;
      W_memtoreg <= M_memtoreg;
      W_rt_rd    <= M_rt_rd;
      W_alu_out  <= M_alu_out;
      W_mem_data <= bus_err ? 32'h0 : load_data;
      W_addr_err <= misaligned;
      W_bus_err  <= bus_err;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: the driver queues hand-computed expectations,
// a negedge monitor checks the bus side, stall length and MEM/WB outputs.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        M_regwrite, M_memtoreg, M_memread, M_memwrite;
  logic [31:0] M_memaddr, M_store_data, M_alu_out;
  logic [8:0]  M_load_op;
  logic [5:0]  M_store_op;
  logic [4:0]  M_rt_rd;
  logic        M_stall, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        W_regwrite, W_memtoreg, W_addr_err, W_bus_err;
  logic [4:0]  W_rt_rd;
  logic [31:0] W_alu_out, W_mem_data;

  int vectors = 0;
  int miscompares = 0;
  logic m_valid = 1'b0;

  typedef struct {
    logic        access;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    int          stalls;
    logic        regwrite;
    logic        memtoreg;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] mem;
    logic        ae;
    logic        berr;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(64), .TO_W(7)) dut (
    .clk(clk), .rst(rst),
    .M_regwrite(M_regwrite), .M_memtoreg(M_memtoreg),
    .M_memread(M_memread), .M_memwrite(M_memwrite),
    .M_memaddr(M_memaddr), .M_load_op(M_load_op), .M_store_op(M_store_op),
    .M_store_data(M_store_data), .M_alu_out(M_alu_out), .M_rt_rd(M_rt_rd),
    .M_stall(M_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .W_regwrite(W_regwrite), .W_memtoreg(W_memtoreg), .W_rt_rd(W_rt_rd),
    .W_alu_out(W_alu_out), .W_mem_data(W_mem_data),
    .W_addr_err(W_addr_err), .W_bus_err(W_bus_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: W outputs are checked the cycle after a transaction retires.
  exp_t w_exp;
  logic w_pend = 1'b0;
  int   stall_cnt = 0;

  always @(negedge clk) begin
    exp_t h;
    if (w_pend) begin
      chk("W_regwrite", {31'b0, W_regwrite}, {31'b0, w_exp.regwrite});
      chk("W_memtoreg", {31'b0, W_memtoreg}, {31'b0, w_exp.memtoreg});
      chk("W_rt_rd",    {27'b0, W_rt_rd},    {27'b0, w_exp.rd});
      chk("W_alu_out",  W_alu_out,           w_exp.alu);
      chk("W_mem_data", W_mem_data,          w_exp.mem);
      chk("W_addr_err", {31'b0, W_addr_err}, {31'b0, w_exp.ae});
      chk("W_bus_err",  {31'b0, W_bus_err},  {31'b0, w_exp.berr});
      $display("xact rd=%0d mem=0x%08h we=%0b ae=%0b be=%0b",
               W_rt_rd, W_mem_data, W_regwrite, W_addr_err, W_bus_err);
      w_pend = 1'b0;
    end
    if (m_valid && sb_q.size() > 0) begin
      h = sb_q[0];
      if (dmem_req) begin
        chk("req_allowed", 32'd1, {31'b0, h.access});
        chk("dmem_addr",  dmem_addr,  h.addr);
        chk("dmem_be",    {28'b0, dmem_be}, {28'b0, h.be});
        chk("dmem_wdata", dmem_wdata, h.wdata);
        chk("dmem_we",    {31'b0, dmem_we}, {31'b0, h.we});
      end
      if (M_stall) begin
        stall_cnt++;
      end else begin
        chk("req_at_done", {31'b0, dmem_req}, {31'b0, h.access & ~h.berr});
        chk("stall_cycles", stall_cnt, h.stalls);
        w_exp  = h;
        w_pend = 1'b1;
        stall_cnt = 0;
        void'(sb_q.pop_front());
      end
    end
  end

  task automatic idle_inputs();
    M_regwrite = 0; M_memtoreg = 0; M_memread = 0; M_memwrite = 0;
    M_memaddr = 0; M_load_op = 0; M_store_op = 0; M_store_data = 0;
    M_alu_out = 0; M_rt_rd = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  // ack_at: cycle index (0 = first cycle) carrying the ack; -1 for none.
  task automatic xact(input logic rd, input logic wr, input logic [8:0] lop,
                      input logic [5:0] sop, input logic [31:0] addr,
                      input logic [31:0] sdata, input logic [31:0] rdata,
                      input logic regw, input logic mtr, input logic [4:0] rdi,
                      input int ack_at, input logic [3:0] e_be,
                      input logic [31:0] e_wdata, input int e_stalls,
                      input logic [31:0] e_mem, input logic e_rw,
                      input logic e_ae, input logic e_berr);
    exp_t e;
    int cyc;
    e.access = (rd | wr) & ~e_ae;
    e.addr = {addr[31:2], 2'b00};
    e.be = e_be; e.wdata = e_wdata; e.we = wr; e.stalls = e_stalls;
    e.regwrite = e_rw; e.memtoreg = mtr; e.rd = rdi; e.alu = addr;
    e.mem = e_mem; e.ae = e_ae; e.berr = e_berr;
    sb_q.push_back(e);
    M_regwrite = regw; M_memtoreg = mtr; M_memread = rd; M_memwrite = wr;
    M_memaddr = addr; M_load_op = lop; M_store_op = sop; M_store_data = sdata;
    M_alu_out = addr; M_rt_rd = rdi; dmem_rdata = rdata;
    m_valid = 1'b1;
    cyc = 0;
    forever begin
      dmem_ack = (cyc == ack_at);
      @(negedge clk);
      if (!M_stall) break;
      if (cyc >= 200) begin
        chk("stall_bound", 32'd1, 32'd0);
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_W_regwrite", {31'b0, W_regwrite}, 32'd0);
    chk("rst_W_alu_out", W_alu_out, 32'd0);
    chk("rst_W_mem_data", W_mem_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // LB same-cycle ack, sign extension of byte 3
    xact(1,0, 9'h001, 6'h0, 32'h1003, 0, 32'h80AB_CDEF, 1,1, 5'd5,  0, 4'hF, 0,  0, 32'hFFFF_FF80, 1,0,0);
    // LHU, ack three cycles late (back-to-back with the previous)
    xact(1,0, 9'h008, 6'h0, 32'h2002, 0, 32'h8001_1234, 1,1, 5'd6,  3, 4'hF, 0,  3, 32'h0000_8001, 1,0,0);
    // SB lane 1
    xact(0,1, 9'h000, 6'h01, 32'h1001, 32'h0000_00A5, 0, 0,0, 5'd7, 0, 4'b0010, 32'hA5A5_A5A5, 0, 0, 0,0,0);
    // LW misaligned: no request
    xact(1,0, 9'h010, 6'h0, 32'h1002, 0, 0, 1,1, 5'd8, -1, 4'hF, 0, 0, 0, 0,1,0);
    // LH upper half, ack one cycle late
    xact(1,0, 9'h004, 6'h0, 32'h1002, 0, 32'h8001_1234, 1,1, 5'd9,  1, 4'hF, 0,  1, 32'hFFFF_8001, 1,0,0);
    // LBU lane 1
    xact(1,0, 9'h002, 6'h0, 32'h1001, 0, 32'h80AB_CDEF, 1,1, 5'd10, 0, 4'hF, 0,  0, 32'h0000_00CD, 1,0,0);
    // SH upper half
    xact(0,1, 9'h000, 6'h02, 32'h2002, 32'h1234_BEEF, 0, 0,0, 5'd11, 0, 4'b1100, 32'hBEEF_BEEF, 0, 0, 0,0,0);
    // SW, ack two cycles late
    xact(0,1, 9'h000, 6'h04, 32'h3000, 32'hDEAD_BEEF, 0, 0,0, 5'd12, 2, 4'b1111, 32'hDEAD_BEEF, 2, 0, 0,0,0);
    // SH misaligned
    xact(0,1, 9'h000, 6'h02, 32'h2001, 32'h1234_5678, 0, 0,0, 5'd13, -1, 4'hF, 0, 0, 0, 0,1,0);
    // Reserved load bit decodes as LW
    xact(1,0, 9'h020, 6'h0, 32'h0010, 0, 32'h1234_5678, 1,1, 5'd14, 0, 4'hF, 0, 0, 32'h1234_5678, 1,0,0);
    // LB|LBU both set: LB wins
    xact(1,0, 9'h003, 6'h0, 32'h0000, 0, 32'h0000_00F0, 1,1, 5'd15, 0, 4'hF, 0, 0, 32'hFFFF_FFF0, 1,0,0);
    // Timeout: never acked
    xact(1,0, 9'h010, 6'h0, 32'h4000, 0, 32'h5555_5555, 1,1, 5'd16, -1, 4'hF, 0, 64, 0, 0,0,1);

    // Reset mid-WAIT, outside the scoreboard
    m_valid = 1'b0;
    M_regwrite = 1; M_memtoreg = 1; M_memread = 1; M_load_op = 9'h010;
    M_memaddr = 32'h3000; M_alu_out = 32'h3000; M_rt_rd = 5'd17;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("wait_req", {31'b0, dmem_req}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_req", {31'b0, dmem_req}, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("rstw_W_alu_out", W_alu_out, 32'd0);
    chk("rstw_W_rt_rd", {27'b0, W_rt_rd}, 32'd0);
    chk("rstw_W_memtoreg", {31'b0, W_memtoreg}, 32'd0);
    chk("rstw_W_bus_err", {31'b0, W_bus_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    dmem_ack = 1'b1;
    @(negedge clk);
    chk("stray_req", {31'b0, dmem_req}, 32'd0);
    chk("stray_stall", {31'b0, M_stall}, 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("stray_W_regwrite", {31'b0, W_regwrite}, 32'd0);
    chk("stray_W_bus_err", {31'b0, W_bus_err}, 32'd0);
    @(posedge clk); #1;

    // Post-reset access behaves normally
    xact(1,0, 9'h001, 6'h0, 32'h1003, 0, 32'h80AB_CDEF, 1,1, 5'd18, 2, 4'hF, 0, 2, 32'hFFFF_FF80, 1,0,0);

    m_valid = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("queue_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS32 pipeline.
- Sits directly downstream of the EX/MEM pipeline register and consumes its M_* fields.
- Drives the data-memory req/ack port and performs load lane extraction and sign/zero extension, plus store byte-enable and lane generation.
- Raises M_stall back to the EX/MEM register while an access is outstanding, and contains the MEM/WB pipeline register that produces the W_* outputs.

Parameters:
- TIMEOUT, 64: max cycles in WAIT before the access is abandoned as a bus error.
- TO_W, 7: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  pipeline clock; all state on the rising edge.
- rst  in  1  synchronous, active-low reset.
- M_regwrite  in  1  register-write enable from EX/MEM.
- M_memtoreg  in  1  writeback selects load data.
- M_memread  in  1  load access.
- M_memwrite  in  1  store access.
- M_memaddr  in  32  byte address.
- M_load_op  in  9  one-hot: [0]LB [1]LBU [2]LH [3]LHU [4]LW; [8:5] reserved, treated as LW.
- M_store_op  in  6  one-hot: [0]SB [1]SH [2]SW; [5:3] reserved, treated as SW.
- M_store_data  in  32  rt value for stores (new EX/MEM field).
- M_alu_out  in  32  ALU result.
- M_rt_rd  in  5  destination register.
- M_stall  out  1  hold EX/MEM and upstream.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word address; low 2 bits forced to 0.
- dmem_be  out  4  byte enables, little-endian lanes.
- dmem_wdata  out  32  store data, lane-replicated.
- dmem_rdata  in  32  read data, valid with ack.
- dmem_ack  in  1  one-cycle completion.
- W_regwrite  out  1  write enable to WB.
- W_memtoreg  out  1  passed through.
- W_rt_rd  out  5  destination.
- W_alu_out  out  32  passed through.
- W_mem_data  out  32  extended load result.
- W_addr_err  out  1  misaligned access (to CP0).
- W_bus_err  out  1  timeout (to CP0).

Behaviour:
- access = (M_memread | M_memwrite) & ~misaligned.
- misaligned: LH/LHU/SH with addr[0]=1, or word op with addr[1:0]!=0.
- A misaligned access issues no request and does not stall.
- FSM has two states, IDLE and WAIT.
- IDLE:
  - dmem_req = access.
  - If access and dmem_ack: complete this cycle.
  - If access and no ack: go to WAIT and clear the counter.
- WAIT:
  - dmem_req held high; addr, be, wdata and we stay stable because inputs are held by M_stall.
  - Counter increments each cycle.
  - dmem_ack: complete and return to IDLE.
  - Counter reaches TIMEOUT-1 with no ack: complete with bus_err, drop req, return to IDLE.
- M_stall = access & ~complete, combinational.
- Stores:
  - SB: be = 1<<addr[1:0], wdata = {4{data[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{data[15:0]}}.
  - SW: be = 4'b1111.
  - Loads drive be = 4'b1111 and wdata = 0.
- Loads: extract the byte/half lane selected by addr[1:0] from the raw read data; LB/LH sign-extend, LBU/LHU zero-extend.
- MEM/WB register, updated every cycle:
  - If M_stall: W_regwrite, W_addr_err and W_bus_err load 0 (bubble); other W fields hold.
  - Else: capture all fields.
  - W_regwrite = M_regwrite & ~misaligned & ~bus_err.
  - W_mem_data = extended load data (0 on bus_err).
- Reset (rst=0):
  - State IDLE, counter 0, dmem_req 0.
  - All W_* outputs 0.
  - Takes effect even mid-WAIT; the outstanding request is abandoned and a late ack is ignored.
- Back-to-back accesses: a new request may assert the cycle after completion; no idle cycle is required.
- Reserved op bits: lower bits take priority; an all-zero op with memread set is treated as LW.

Decomposition:
- Shared package mips_pkg holds:
  - Load one-hot bit indices (LD_LB..LD_LW).
  - Store bit indices (ST_SB..ST_SW).
  - FSM state encoding.
- One sub-module, mem_align: combinational store byte-enable/lane generation and load extraction/extension.
- The FSM, timeout counter and MEM/WB register stay in mem_stage.

Test Plan:
- LB, addr 0x1003, rdata 0x80AB_CDEF, ack in the same cycle -> M_stall never asserts; next cycle W_mem_data=0xFFFF_FF80, W_regwrite=1.
- LHU, addr 0x2002, ack delayed 3 cycles, rdata 0x8001_1234 -> M_stall high 3 cycles, req stable; W_mem_data=0x0000_8001.
- SB, addr 0x1001, data 0x0000_00A5 -> dmem_be=4'b0010, dmem_wdata=0xA5A5_A5A5, dmem_addr=0x1000, dmem_we=1.
- LW, addr 0x1002 -> no dmem_req; next cycle W_addr_err=1, W_regwrite=0.
- Load with no ack, TIMEOUT=64 -> M_stall high 64 cycles; then W_bus_err=1, W_regwrite=0, req dropped.
- rst=0 during cycle 2 of WAIT, ack arrives after release -> req 0, all W_* 0, state IDLE, stray ack ignored.
